// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the RF packet transfer sequencer.
//   state_t  : sequencer FSM states
//   BYTE_W   : byte index width for the default packet size
//   BIT_W    : TX bit counter width for the default frame size
//   CS_IDLE  : deasserted level of the active-low SPI chip select
//   cnt_w()  : counter width for n states, never less than 1
package pkt_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_WAIT_LO,
    S_RX_XFER,
    S_TX_WAIT_HI,
    S_TX_SHIFT
  } state_t;

  localparam int NBYTES_DEF = 8;
  localparam int BITS_DEF   = 8;
  localparam int BYTE_W     = $clog2(NBYTES_DEF);
  localparam int BIT_W      = $clog2(BITS_DEF);

  localparam logic CS_IDLE = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_xfer_sched_cs_sync.sv
// CS synchroniser and edge detector.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset (flops reset to CS idle level)
//   i_cs      : raw SPI chip select, asynchronous to i_clk
//   o_cs_s    : synchronised chip select
//   o_cs_fall : one-cycle strobe, synchronised CS went low
//   o_cs_rise : one-cycle strobe, synchronised CS went high
module cs_sync
  import pkt_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cs,
  output logic o_cs_s,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_cs_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{CS_IDLE}};
      r_cs_q <= CS_IDLE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_cs};
      r_cs_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_cs_s    = r_sync[SYNC_STAGES-1];
  assign o_cs_fall = ~o_cs_s & r_cs_q;
  assign o_cs_rise = o_cs_s & ~r_cs_q;

endmodule

// File: rtl/pkt_xfer_sched.sv
// Sequencing controller for the RF packet datapath.
//   RX: packet-received edge loads the packet register, then one byte is
//       read per CS frame (byte_sel/byte_adv); after the last byte the
//       shift buffer is cleared and done pulses.
//   TX: after an SPI write frame, tx_ld loads the TX buffer and exactly
//       BITS sh_en strobes are passed through as tx_en.
// Ports:
//   clk, PRESETn           : clock, asynchronous active-low reset
//   rx_mode                : 1 = RX sequencing, 0 = TX (sampled in IDLE)
//   pkt_rec, cs, sh_en     : packet level, raw chip select, bit strobe
//   ovf_clr                : clears the sticky overrun flag
//   pkt_ld, byte_adv, pkt_clr, tx_ld, done : registered one-cycle pulses
//   byte_sel               : byte index presented to the SPI slave
//   tx_en                  : TX shift enable (sh_en gated by TX_SHIFT)
//   busy                   : sequencer not idle
//   ovf                    : sticky overrun flag
module pkt_xfer_sched
  import pkt_sched_pkg::*;
#(
  parameter  int NBYTES      = NBYTES_DEF,
  parameter  int BITS        = BITS_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = cnt_w(NBYTES),
  localparam int CNT_W       = cnt_w(BITS)
) (
  input  logic             clk,
  input  logic             PRESETn,
  input  logic             rx_mode,
  input  logic             pkt_rec,
  input  logic             cs,
  input  logic             sh_en,
  input  logic             ovf_clr,
  output logic             pkt_ld,
  output logic [SEL_W-1:0] byte_sel,
  output logic             byte_adv,
  output logic             pkt_clr,
  output logic             tx_ld,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  logic w_cs_s;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_pkt_rise;

  cs_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cs_sync (
    .i_clk    (clk),
    .i_rst_n  (PRESETn),
    .i_cs     (cs),
    .o_cs_s   (w_cs_s),
    .o_cs_fall(w_cs_fall),
    .o_cs_rise(w_cs_rise)
  );

  logic r_pkt_rec_q;

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) r_pkt_rec_q <= 1'b0;
    else          r_pkt_rec_q <= pkt_rec;
  end

  assign w_pkt_rise = pkt_rec & ~r_pkt_rec_q;

  state_t           r_state,    w_state_nx;
  logic [SEL_W-1:0] r_byte_sel, w_sel_nx;
  logic [CNT_W-1:0] r_bit_cnt,  w_cnt_nx;
  logic             r_pkt_ld,   w_ld_nx;
  logic             r_byte_adv, w_adv_nx;
  logic             r_pkt_clr,  w_clr_nx;
  logic             r_tx_ld,    w_txld_nx;
  logic             r_done,     w_done_nx;
  logic             r_ovf,      w_ovf_nx;

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_byte_sel <= '0;
      r_bit_cnt  <= '0;
      r_pkt_ld   <= 1'b0;
      r_byte_adv <= 1'b0;
      r_pkt_clr  <= 1'b0;
      r_tx_ld    <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_byte_sel <= w_sel_nx;
      r_bit_cnt  <= w_cnt_nx;
      r_pkt_ld   <= w_ld_nx;
      r_byte_adv <= w_adv_nx;
      r_pkt_clr  <= w_clr_nx;
      r_tx_ld    <= w_txld_nx;
      r_done     <= w_done_nx;
      r_ovf      <= w_ovf_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_byte_sel;
    w_cnt_nx   = r_bit_cnt;
    w_ld_nx    = 1'b0;
    w_adv_nx   = 1'b0;
    w_clr_nx   = 1'b0;
    w_txld_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_ovf_nx   = r_ovf;

    // Clear first so a coincident overrun still sets the flag.
    if (ovf_clr) w_ovf_nx = 1'b0;
    if ((w_pkt_rise && (r_state != S_IDLE)) ||
        (w_cs_fall  && (r_state == S_TX_SHIFT)))
      w_ovf_nx = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (rx_mode && w_pkt_rise) begin
          w_ld_nx    = 1'b1;
          w_sel_nx   = '0;
          w_state_nx = S_RX_WAIT_LO;
        end else if (!rx_mode && w_cs_fall) begin
          w_state_nx = S_TX_WAIT_HI;
        end
      end
      S_RX_WAIT_LO: begin
        if (w_cs_fall) w_state_nx = S_RX_XFER;
      end
      S_RX_XFER: begin
        if (w_cs_rise) begin
          w_adv_nx = 1'b1;
          if (r_byte_sel == SEL_W'(NBYTES - 1)) begin
            w_clr_nx   = 1'b1;
            w_done_nx  = 1'b1;
            w_sel_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_sel_nx   = r_byte_sel + SEL_W'(1);
            w_state_nx = S_RX_WAIT_LO;
          end
        end
      end
      S_TX_WAIT_HI: begin
        // Frame is closed once CS is back at its idle level.
        if (w_cs_rise && (w_cs_s == CS_IDLE)) begin
          w_txld_nx  = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = S_TX_SHIFT;
        end
      end
      S_TX_SHIFT: begin
        if (sh_en) begin
          if (r_bit_cnt == CNT_W'(BITS - 1)) begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign pkt_ld   = r_pkt_ld;
  assign byte_sel = r_byte_sel;
  assign byte_adv = r_byte_adv;
  assign pkt_clr  = r_pkt_clr;
  assign tx_ld    = r_tx_ld;
  assign done     = r_done;
  assign ovf      = r_ovf;
  assign busy     = (r_state != S_IDLE);
  assign tx_en    = sh_en & (r_state == S_TX_SHIFT);

endmodule

// File: tb/tb_pkt_xfer_sched.sv
module tb_pkt_xfer_sched;

  localparam int NBYTES = 8;
  localparam int BITS   = 8;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 1;

  logic       clk = 1'b0;
  logic       PRESETn, rx_mode, pkt_rec, cs, sh_en, ovf_clr;
  logic       pkt_ld, byte_adv, pkt_clr, tx_ld, tx_en, busy, done, ovf;
  logic [2:0] byte_sel;

  pkt_xfer_sched #(
    .NBYTES     (NBYTES),
    .BITS       (BITS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .PRESETn (PRESETn),
    .rx_mode (rx_mode),
    .pkt_rec (pkt_rec),
    .cs      (cs),
    .sh_en   (sh_en),
    .ovf_clr (ovf_clr),
    .pkt_ld  (pkt_ld),
    .byte_sel(byte_sel),
    .byte_adv(byte_adv),
    .pkt_clr (pkt_clr),
    .tx_ld   (tx_ld),
    .tx_en   (tx_en),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event monitor: counts output pulses and remembers when they occurred.
  int n_ld, n_adv, n_clr, n_done, n_txld, n_txen, n_stray;
  int ld_cyc, clr_cyc, done_cyc, txld_cyc;
  always @(negedge clk) begin
    if (pkt_ld)   begin n_ld++;   ld_cyc   = cyc; end
    if (byte_adv) n_adv++;
    if (pkt_clr)  begin n_clr++;  clr_cyc  = cyc; end
    if (done)     begin n_done++; done_cyc = cyc; end
    if (tx_ld)    begin n_txld++; txld_cyc = cyc; end
    if (tx_en)    n_txen++;
    if (tx_en && !busy) n_stray++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_ld = 0; n_adv = 0; n_clr = 0; n_done = 0; n_txld = 0; n_txen = 0;
    ld_cyc = -1; clr_cyc = -1; done_cyc = -1; txld_cyc = -1;
  endtask

  // One SPI read frame; byte k must be presented while CS is low.
  // With glitch set, a fresh packet edge arrives mid-frame (overrun).
  int last_rise;
  task automatic rx_frame(input int k, input bit glitch);
    cs = 1'b0;
    tick($urandom_range(5, 8));
    if (glitch) begin
      pkt_rec = 1'b0; tick(1);
      pkt_rec = 1'b1; tick(1);
    end
    chk($sformatf("byte_sel_frame%0d", k), byte_sel, k);
    cs = 1'b1;
    last_rise = cyc;
    tick($urandom_range(5, 8));
  endtask

  task automatic start_pkt();
    pkt_rec = 1'b0; tick(2);
    rx_mode = 1'b1;
    pkt_rec = 1'b1; tick(1);
  endtask

  task automatic tx_frame();
    int r;
    cs = 1'b0;
    tick($urandom_range(5, 8));
    cs = 1'b1;
    r = cyc;
    for (int i = 0; i < 20 && n_txld == 0; i++) tick(1);
    chk("tx_ld_seen", n_txld, 1);
    chk("tx_ld_latency", txld_cyc - r, LAT);
  endtask

  task automatic strobe();
    sh_en = 1'b1; tick(1);
    sh_en = 1'b0; tick($urandom_range(0, 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    int s8;
    PRESETn = 1'b0; rx_mode = 1'b0; pkt_rec = 1'b0; cs = 1'b1;
    sh_en = 1'b0; ovf_clr = 1'b0;
    clr_counts();
    tick(3);

    // Reset state
    chk("reset_outputs", {pkt_ld, byte_adv, pkt_clr, tx_ld, tx_en, busy, done, ovf}, 0);
    chk("reset_byte_sel", byte_sel, 0);
    PRESETn = 1'b1;
    tick(10);
    chk("idle_no_pulses", n_ld + n_adv + n_clr + n_done + n_txld + n_txen, 0);

    // IDLE ignores packet edges in TX mode and CS frames in RX mode
    pkt_rec = 1'b1; tick(4);
    chk("tx_mode_pkt_ignored", {pkt_ld, busy, ovf}, 0);
    pkt_rec = 1'b0; rx_mode = 1'b1; tick(2);
    cs = 1'b0; tick(6); cs = 1'b1; tick(6);
    chk("rx_mode_cs_ignored", n_ld + n_txld + n_adv + int'(busy), 0);

    // Full RX packet; rx_mode noise while busy is ignored, held pkt_rec does not retrigger
    clr_counts();
    tick($urandom_range(1, 4));
    pkt_rec = 1'b1; p = cyc;
    tick(2);
    chk("rx_pkt_ld_once", n_ld, 1);
    chk("rx_pkt_ld_latency", ld_cyc - p, 1);
    chk("rx_busy", busy, 1);
    rx_mode = 1'($urandom_range(0, 1));
    for (int k = 0; k < NBYTES; k++) rx_frame(k, 1'b0);
    chk("rx_adv_count", n_adv, NBYTES);
    chk("rx_clr_once", n_clr, 1);
    chk("rx_done_once", n_done, 1);
    chk("rx_clr_with_done", clr_cyc, done_cyc);
    chk("rx_clr_latency", clr_cyc - last_rise, LAT);
    chk("rx_idle_after", busy, 0);
    chk("rx_no_retrigger", n_ld, 1);
    chk("rx_no_ovf", ovf, 0);

    // Overrun: second packet edge during frame 3
    clr_counts();
    start_pkt();
    for (int k = 0; k < NBYTES; k++) rx_frame(k, k == 2);
    chk("ovr_ovf_set", ovf, 1);
    chk("ovr_pkt_dropped", n_ld, 1);
    chk("ovr_adv_count", n_adv, NBYTES);
    chk("ovr_done", n_done, 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
    chk("ovf_cleared", ovf, 0);

    // Overrun set coincides with clear: set wins
    clr_counts();
    start_pkt();
    tick(2);
    pkt_rec = 1'b0; tick(1);
    pkt_rec = 1'b1; ovf_clr = 1'b1; tick(1);
    ovf_clr = 1'b0; tick(1);
    chk("set_beats_clear", ovf, 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
    chk("ovf_cleared2", ovf, 0);
    for (int k = 0; k < NBYTES; k++) rx_frame(k, 1'b0);
    chk("pkt2_done", n_done, 1);
    chk("pkt2_idle", busy, 0);

    // TX: one write frame, 10 strobes, exactly BITS enables
    pkt_rec = 1'b0; rx_mode = 1'b0; tick(3);
    clr_counts();
    tx_frame();
    chk("tx_busy", busy, 1);
    s8 = -1;
    for (int i = 0; i < 10; i++) begin
      sh_en = 1'b1; tick(1);
      if (i == BITS - 1) s8 = cyc;
      sh_en = 1'b0; tick($urandom_range(0, 2));
    end
    tick(2);
    chk("tx_en_count", n_txen, BITS);
    chk("tx_done_once", n_done, 1);
    chk("tx_done_latency", done_cyc - s8, 0);
    chk("tx_idle_after", busy, 0);

    // TX: CS falls during shift after 3 bits -> overrun, shift still completes
    clr_counts();
    tx_frame();
    for (int i = 0; i < 3; i++) strobe();
    cs = 1'b0; tick(6);
    cs = 1'b1; tick(6);
    chk("tx_cs_ovf", ovf, 1);
    chk("tx_cs_still_busy", busy, 1);
    for (int i = 0; i < 7; i++) strobe();
    tick(2);
    chk("tx_cs_en_count", n_txen, BITS);
    chk("tx_cs_no_reload", n_txld, 1);
    chk("tx_cs_done", n_done, 1);
    chk("tx_cs_idle", busy, 0);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);

    // Reset in RX_XFER at byte 4, then a clean restart from byte 0
    clr_counts();
    start_pkt();
    for (int k = 0; k < 4; k++) rx_frame(k, 1'b0);
    cs = 1'b0; tick(6);
    chk("pre_reset_sel", byte_sel, 4);
    PRESETn = 1'b0;
    #1;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_sel", byte_sel, 0);
    pkt_rec = 1'b0; cs = 1'b1;
    tick(2);
    chk("reset_mid_no_clr", n_clr, 0);
    PRESETn = 1'b1; tick(3);
    start_pkt();
    for (int k = 0; k < NBYTES; k++) rx_frame(k, 1'b0);
    chk("restart_adv", n_adv, 4 + NBYTES);
    chk("restart_clr", n_clr, 1);
    chk("restart_done", n_done, 1);
    chk("restart_idle", busy, 0);
    chk("tx_en_only_busy", n_stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_xfer_sched.md
Name: pkt_xfer_sched

Overview:
Sequencing controller for the RF packet datapath (shift buffer, packet register, SPI slave and TX buffer).
- RX mode: on each received packet, loads the packet register, then steps the SPI slave through NBYTES byte reads, one per CS frame, and clears the shift buffer when all bytes have been read.
- TX mode: after an SPI write frame, loads the TX buffer and gates exactly BITS shift enables.
- Replaces ad-hoc sequencing at top level with one synchronised, overrun-checked FSM.

Parameters:
NBYTES, 8, bytes per packet read over SPI (packet width = 8*NBYTES)
BITS, 8, TX bits shifted out per SPI write frame
SYNC_STAGES, 2, flops in the CS synchroniser (min 2)

Ports:
clk  input  1  system clock
PRESETn  input  1  asynchronous active-low reset
rx_mode  input  1  1 = RX sequencing, 0 = TX sequencing; sampled only in IDLE
pkt_rec  input  1  packet-received level from shift buffer (clk domain)
cs  input  1  raw SPI chip select, active low, asynchronous to clk
sh_en  input  1  bit-period strobe from SH_SYNC (clk domain)
ovf_clr  input  1  clears ovf
pkt_ld  output  1  one-cycle pulse: load packet register
byte_sel  output  $clog2(NBYTES)  index of byte presented to SPI slave
byte_adv  output  1  one-cycle pulse: byte consumed, register advances
pkt_clr  output  1  one-cycle pulse: reset shift buffer
tx_ld  output  1  one-cycle pulse: load TX buffer from SPI output
tx_en  output  1  TX buffer shift enable
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse: RX packet or TX byte sequence complete
ovf  output  1  sticky overrun flag

Behaviour:
- Reset (PRESETn low, async): FSM=IDLE; all outputs 0, byte_sel=0, ovf=0.
  - CS synchroniser flops reset to 1 (deasserted); pkt_rec_q=0; bit_cnt=0.
- CS handling:
  - cs passes through SYNC_STAGES flops to give cs_s; cs_q = cs_s delayed one cycle.
  - cs_fall = ~cs_s & cs_q; cs_rise = cs_s & ~cs_q.
  - A CS edge reaches the FSM SYNC_STAGES+1 cycles after the pin.
- pkt_rise = pkt_rec & ~pkt_rec_q (pkt_rec_q is pkt_rec registered once).
- States: IDLE, RX_WAIT_LO, RX_XFER, TX_WAIT_HI, TX_SHIFT. All pulse outputs are registered.
- IDLE:
  - If rx_mode and pkt_rise: next cycle pkt_ld=1, byte_sel=0, go to RX_WAIT_LO.
  - Else if !rx_mode and cs_fall: go to TX_WAIT_HI.
  - All other events are ignored.
- RX_WAIT_LO: on cs_fall, go to RX_XFER.
- RX_XFER: on cs_rise, byte_adv=1.
  - If byte_sel==NBYTES-1: pkt_clr=1, done=1, byte_sel=0, go to IDLE (all three pulses in the same cycle).
  - Otherwise byte_sel+1 and go to RX_WAIT_LO.
- TX_WAIT_HI: on cs_rise, tx_ld=1, bit_cnt=0, go to TX_SHIFT.
- TX_SHIFT:
  - tx_en = sh_en while in TX_SHIFT (combinational AND with state); bit_cnt increments on each sh_en.
  - On the sh_en where bit_cnt==BITS-1: done=1 next cycle, go to IDLE.
  - tx_en is never high outside TX_SHIFT.
- Overrun: ovf is set when pkt_rise occurs in any non-IDLE state (that packet is dropped, sequence continues), or when cs_fall occurs in TX_SHIFT (ignored).
  - ovf_clr clears ovf; if a set and a clear coincide, set wins.
- rx_mode changes outside IDLE are ignored until return to IDLE.
- pkt_rec held high does not retrigger; only rising edges count.
- busy = (state != IDLE), combinational.
- Reset mid-sequence returns to IDLE immediately with no pkt_clr pulse.

Decomposition:
- Package pkt_sched_pkg holds:
  - state enum;
  - localparams BYTE_W = $clog2(NBYTES) and BIT_W = $clog2(BITS);
  - CS idle level constant.
- One sub-module, cs_sync: SYNC_STAGES synchroniser plus edge detector, outputs cs_s, cs_fall and cs_rise, asynchronous reset to 1.

Test Plan:
- Reset with cs=1: all outputs 0, busy=0; release PRESETn, hold 10 cycles -> no pulses.
- rx_mode=1, pkt_rec rises -> pkt_ld single pulse, byte_sel=0; then 8 CS frames -> byte_sel steps 0..7, 8 byte_adv pulses; after the 8th cs rise, pkt_clr and done pulse in the same cycle, busy=0.
- rx_mode=1, second pkt_rec rise during frame 3 -> ovf=1, byte_sel continues to 7 unaffected; ovf_clr -> ovf=0.
- rx_mode=0, one CS frame -> tx_ld pulse SYNC_STAGES+1 cycles after the cs rise; 10 sh_en strobes -> exactly 8 tx_en cycles, then done, IDLE.
- TX_SHIFT with cs falling after 3 bits -> ovf=1, shift completes 8 bits.
- PRESETn asserted in RX_XFER at byte 4 -> immediate IDLE, byte_sel=0, no pkt_clr; the next packet restarts at byte 0.
